uart_tx_fifo: RTL

Transmit-side buffer that sits directly upstream of the UART transmitter. Host writes are accepted at full clock rate and presented to the transmitter as a first-word-fall-through (FWFT) stream. The transmitter samples `rd_data` while `rd_valid` is high and pops the word with a single-cycle `rd_en` pulse. Level, almost-full and sticky overflow/underflow status feed the register block and interrupt logic.

---
 rtl/uart_tx_fifo_if.sv | 22 ++
 rtl/uart_tx_fifo.sv | 89 ++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Host-write / transmitter-read handshake bundle for the UART transmit FIFO.
// master = host plus transmitter side, slave = FIFO.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_ready, rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through transmit buffer between the host and the UART
// transmitter, with level, almost-full and sticky overflow/underflow status.
module uart_tx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       clr_status,
  uart_tx_fifo_if.slave              bus,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   AFULL_CMP = (AW+1)'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0] rd_ptr_reg, rd_ptr_next;
  logic        overflow_reg, overflow_next;
  logic        underflow_reg, underflow_next;
  logic        wr_accept, rd_accept;

  // All status is a function of the registered pointers only.
  assign empty       = (wr_ptr_reg == rd_ptr_reg);
  assign full        = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                       (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign level       = wr_ptr_reg - rd_ptr_reg;
  assign almost_full = (level >= AFULL_CMP);
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

  assign bus.wr_ready = !full;
  assign bus.rd_valid = !empty;
  // Forced to zero while empty so stale storage never reaches the transmitter.
  assign bus.rd_data  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  assign wr_accept = bus.wr_en && !full  && !flush;
  assign rd_accept = bus.rd_en && !empty && !flush;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    overflow_next  = overflow_reg  & ~clr_status;
    underflow_next = underflow_reg & ~clr_status;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (wr_accept)
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (rd_accept)
        rd_ptr_next = rd_ptr_reg + PTR_ONE;
      // A set event in the same cycle as clr_status keeps the flag high.
      if (bus.wr_en && full)
        overflow_next = 1'b1;
      if (bus.rd_en && empty)
        underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage carries no reset; empty-masking of rd_data covers its contents.
  always_ff @(posedge clk) begin
    if (wr_accept)
      mem[wr_ptr_reg[AW-1:0]] <= bus.wr_data;
  end
endmodule
